myo_spi_frame_slave: RTL and testbench

- Motor-board end of the myo SPI link.
- Receives the fixed 12-word command frame from the FPGA-side frame controller (header word, PWM reference, padding) and shifts status words back on MISO: position hi/lo, velocity, current, displacement, sensor1, sensor2.
- Oversamples SCLK/SS_N/MOSI in the local clock domain.
- Publishes the PWM reference only from complete, well-formed frames.

---
 rtl/myo_spi_frame_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_myo_spi_frame_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/myo_spi_frame_slave.sv
// -----------------------------------------------------------------------------
// myo_spi_frame_slave
//
// Motor-board end of the myo SPI link (SPI mode 0, MSB first). The FPGA-side
// master sends a fixed frame of WORDS_PER_FRAME words: a header word, the PWM
// reference, then padding. While it clocks that frame in, this block clocks
// status words back on MISO. Slots below STATUS_FIRST_SLOT carry zero. The
// remaining slots carry position hi, position lo, velocity, current,
// displacement, sensor1 and sensor2. All status inputs are captured in one
// cycle at frame start.
//
// SCLK, SS_N and MOSI are oversampled in the local clock domain, which must run
// at 8x SCLK or faster. The PWM reference is published only from a complete,
// well-formed frame.
//
// Ports
//   i_clock         system clock
//   i_reset         asynchronous, active-high reset
//   i_sclk          SPI clock from master (idle low, sample on rising edge)
//   i_ss_n          SPI slave select, active low
//   i_mosi          SPI data from master
//   o_miso          SPI data to master (driven 0 outside a frame)
//   i_position      signed encoder position (32 bit)
//   i_velocity      signed velocity
//   i_current       signed motor current
//   i_displacement  signed spring displacement
//   i_sensor1/2     signed auxiliary sensors
//   o_pwm_ref       signed PWM reference from the last good frame
//   o_pwm_valid     one-cycle pulse when o_pwm_ref updates
//   o_frame_done    one-cycle pulse at the end of every frame
//   o_frame_error   sticky error flag, cleared at the start of the next frame
// -----------------------------------------------------------------------------
module myo_spi_frame_slave #(
  parameter int                   WORDS_PER_FRAME   = 12,
  parameter int                   WORD_BITS         = 16,
  parameter int                   STATUS_FIRST_SLOT = 5,
  parameter logic [WORD_BITS-1:0] HEADER_WORD       = 16'h8000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_sclk,
  input  logic               i_ss_n,
  input  logic               i_mosi,
  output logic               o_miso,
  input  logic signed [31:0] i_position,
  input  logic signed [15:0] i_velocity,
  input  logic signed [15:0] i_current,
  input  logic signed [15:0] i_displacement,
  input  logic signed [15:0] i_sensor1,
  input  logic signed [15:0] i_sensor2,
  output logic signed [15:0] o_pwm_ref,
  output logic               o_pwm_valid,
  output logic               o_frame_done,
  output logic               o_frame_error
);

  localparam int BIT_CW      = $clog2(WORD_BITS);
  localparam int WORD_CW     = $clog2(WORDS_PER_FRAME + 1);
  localparam int STATUS_WRDS = 7;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  // The master masks bit 15 of the reference, so bit 14 is the sign.
  function automatic logic signed [15:0] pwm_from_cand(input logic [14:0] cand);
    return {cand[14], cand};
  endfunction

  // Synchronisers: bit 1 is the synchronised level and bit 2 is its previous
  // value for edge detection. They reset low so that, when the reset ends
  // inside a frame, no ss_n falling edge appears until the master deselects
  // and selects again.
  logic [2:0] r_sclk_sync;
  logic [2:0] r_ss_sync;
  logic [1:0] r_mosi_sync;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[1:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_mosi;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_mosi      = r_mosi_sync[1];

  state_t                r_state;
  logic [BIT_CW-1:0]     r_bit_cnt;
  logic [WORD_CW-1:0]    r_word_cnt;
  logic [WORD_BITS-2:0]  r_rx;        // bits received so far in the current word
  logic [WORD_BITS-1:0]  r_tx;        // TX bits still to send, left aligned
  logic [14:0]           r_pwm_cand;
  logic [WORD_BITS-1:0]  r_shadow [STATUS_WRDS];
  logic                  r_start_pend;
  logic                  r_miso;
  logic signed [15:0]    r_pwm_ref;
  logic                  r_pwm_valid;
  logic                  r_frame_done;
  logic                  r_frame_error;

  logic [WORD_BITS-1:0]  w_rx_word;
  logic [WORD_BITS-1:0]  w_slot_word;

  assign w_rx_word = {r_rx, w_mosi};

  // TX word for the slot selected by the current word count.
  always_comb begin
    w_slot_word = '0;
    for (int k = 0; k < STATUS_WRDS; k++) begin
      if (r_word_cnt == WORD_CW'(STATUS_FIRST_SLOT + k)) w_slot_word = r_shadow[k];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_pwm_cand    <= '0;
      for (int k = 0; k < STATUS_WRDS; k++) r_shadow[k] <= '0;
      r_start_pend  <= 1'b0;
      r_miso        <= 1'b0;
      r_pwm_ref     <= '0;
      r_pwm_valid   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_pwm_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall || r_start_pend) begin
            r_start_pend  <= 1'b0;
            r_state       <= SHIFT;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_frame_error <= 1'b0;
            // Atomic snapshot keeps position hi/lo coherent for the frame.
            r_shadow[0]   <= i_position[31:16];
            r_shadow[1]   <= i_position[15:0];
            r_shadow[2]   <= i_velocity;
            r_shadow[3]   <= i_current;
            r_shadow[4]   <= i_displacement;
            r_shadow[5]   <= i_sensor1;
            r_shadow[6]   <= i_sensor2;
            // Slot 0 is always zero.
            r_tx          <= '0;
          end
        end

        SHIFT: begin
          if (w_ss_rise) begin
            r_state <= FINISH;
            r_miso  <= 1'b0;
            if (r_word_cnt != WORD_CW'(WORDS_PER_FRAME) || r_bit_cnt != '0)
              r_frame_error <= 1'b1;
          end else begin
            if (w_sclk_rise) begin
              if (r_word_cnt == WORD_CW'(WORDS_PER_FRAME)) begin
                r_frame_error <= 1'b1;   // overrun: flag, drop the bit
              end else begin
                r_rx <= w_rx_word[WORD_BITS-2:0];
                if (r_bit_cnt == BIT_CW'(WORD_BITS - 1)) begin
                  r_bit_cnt  <= '0;
                  r_word_cnt <= r_word_cnt + WORD_CW'(1);
                  if (r_word_cnt == '0 && w_rx_word != HEADER_WORD)
                    r_frame_error <= 1'b1;
                  if (r_word_cnt == WORD_CW'(1))
                    r_pwm_cand <= w_rx_word[14:0];
                end else begin
                  r_bit_cnt <= r_bit_cnt + BIT_CW'(1);
                end
              end
            end
            if (w_sclk_fall) begin
              if (r_word_cnt >= WORD_CW'(WORDS_PER_FRAME)) begin
                r_miso <= 1'b0;
                r_tx   <= '0;
              end else if (r_bit_cnt == '0) begin
                // Word boundary: present the MSB of the next slot.
                r_miso <= w_slot_word[WORD_BITS-1];
                r_tx   <= {w_slot_word[WORD_BITS-2:0], 1'b0};
              end else begin
                r_miso <= r_tx[WORD_BITS-1];
                r_tx   <= {r_tx[WORD_BITS-2:0], 1'b0};
              end
            end
          end
        end

        FINISH: begin
          r_state      <= IDLE;
          r_miso       <= 1'b0;
          r_frame_done <= 1'b1;
          if (!r_frame_error) begin
            r_pwm_ref   <= pwm_from_cand(r_pwm_cand);
            r_pwm_valid <= 1'b1;
          end
          // A select arriving now must still start the next frame from IDLE.
          if (w_ss_fall) r_start_pend <= 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_miso        = r_miso;
  assign o_pwm_ref     = r_pwm_ref;
  assign o_pwm_valid   = r_pwm_valid;
  assign o_frame_done  = r_frame_done;
  assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_myo_spi_frame_slave.sv
module tb_myo_spi_frame_slave;

  localparam int HALF = 5;   // SCLK half period in system clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso;
  logic signed [31:0] position = '0;
  logic signed [15:0] velocity = '0, current = '0, displacement = '0;
  logic signed [15:0] sensor1 = '0, sensor2 = '0;
  logic signed [15:0] pwm_ref;
  logic pwm_valid, frame_done, frame_error;

  always #5 clk = ~clk;

  myo_spi_frame_slave dut (
    .i_clock(clk), .i_reset(rst), .i_sclk(sclk), .i_ss_n(ss_n), .i_mosi(mosi),
    .o_miso(miso), .i_position(position), .i_velocity(velocity),
    .i_current(current), .i_displacement(displacement),
    .i_sensor1(sensor1), .i_sensor2(sensor2), .o_pwm_ref(pwm_ref),
    .o_pwm_valid(pwm_valid), .o_frame_done(frame_done), .o_frame_error(frame_error)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] tx_words [13];
  logic [15:0] exp_q [$];

  // Output event monitor
  int valid_cnt = 0;
  int done_cnt = 0;
  logic [15:0] last_pwm = '0;
  always @(negedge clk) begin
    if (pwm_valid) begin
      valid_cnt = valid_cnt + 1;
      last_pwm = pwm_ref;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_words(input logic [15:0] w0, input logic [15:0] w1);
    for (int i = 0; i < 13; i++) tx_words[i] = 16'h0000;
    tx_words[0] = w0;
    tx_words[1] = w1;
  endtask

  // Scoreboard: expected MISO words for a frame, from the bench's own status values.
  task automatic push_expected(input int n);
    logic [15:0] e [12];
    for (int i = 0; i < 5; i++) e[i] = 16'h0000;
    e[5] = position[31:16];
    e[6] = position[15:0];
    e[7] = velocity;
    e[8] = current;
    e[9] = displacement;
    e[10] = sensor1;
    e[11] = sensor2;
    for (int i = 0; i < n && i < 12; i++) exp_q.push_back(e[i]);
  endtask

  task automatic xfer(input int nwords, input bit chk, input int gap);
    logic [15:0] rxw;
    ss_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      rxw = '0;
      for (int b = 15; b >= 0; b--) begin
        mosi = tx_words[w][b];
        repeat (HALF) @(negedge clk);
        rxw[b] = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
      end
      if (chk && w < 12) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL miso_word%0d: got %h but no expected word queued", w, rxw);
        end else begin
          logic [15:0] ex;
          ex = exp_q.pop_front();
          if (rxw !== ex) begin
            n_fail++;
            $display("FAIL miso_word%0d: got %h expected %h", w, rxw, ex);
          end
        end
      end
    end
    repeat (HALF) @(negedge clk);
    ss_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", miso); end
    n_checks++; if (pwm_ref !== 16'sh0000) begin n_fail++; $display("FAIL reset_pwm_ref: got %h expected 0000", pwm_ref); end
    n_checks++; if (pwm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_valid: got %b expected 0", pwm_valid); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame;
    int v0, d0;
    position = 32'sh0001_0002; velocity = 16'sd3; current = 16'sd4;
    displacement = 16'sd5; sensor1 = 16'sd6; sensor2 = 16'sd7;
    set_words(16'h8000, 16'h1234);
    v0 = valid_cnt; d0 = done_cnt;
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (pwm_ref !== 16'sh1234) begin n_fail++; $display("FAIL good_pwm_ref: got %h expected 1234", pwm_ref); end
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL good_pwm_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (last_pwm !== 16'h1234) begin n_fail++; $display("FAIL good_pwm_at_valid: got %h expected 1234", last_pwm); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL good_frame_done: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL good_frame_error: got %b expected 0", frame_error); end
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL good_miso_idle: got %b expected 0", miso); end
  endtask

  task automatic test_negative_pwm;
    int v0;
    set_words(16'h8000, 16'h7F38);
    v0 = valid_cnt;
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (pwm_ref !== 16'shFF38) begin n_fail++; $display("FAIL neg_pwm_ref: got %h expected ff38", pwm_ref); end
    n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL neg_pwm_valid: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_bad_header;
    int v0, d0;
    set_words(16'h0000, 16'h0100);
    v0 = valid_cnt; d0 = done_cnt;
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL badhdr_frame_error: got %b expected 1", frame_error); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL badhdr_frame_done: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL badhdr_pwm_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (pwm_ref !== 16'shFF38) begin n_fail++; $display("FAIL badhdr_pwm_hold: got %h expected ff38", pwm_ref); end
  endtask

  task automatic test_short_frame;
    int v0, d0;
    set_words(16'h8000, 16'h0AAA);
    v0 = valid_cnt; d0 = done_cnt;
    push_expected(5);
    xfer(5, 1'b1, 10);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL short_frame_error: got %b expected 1", frame_error); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL short_pwm_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL short_frame_done: got %0d expected 1", done_cnt - d0); end
    set_words(16'h8000, 16'h0321);
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL short_recover_error: got %b expected 0", frame_error); end
    n_checks++; if (pwm_ref !== 16'sh0321) begin n_fail++; $display("FAIL short_recover_pwm: got %h expected 0321", pwm_ref); end
  endtask

  task automatic test_no_sclk;
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    xfer(0, 1'b0, 10);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL nosclk_frame_error: got %b expected 1", frame_error); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL nosclk_frame_done: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL nosclk_pwm_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (pwm_ref !== 16'sh0321) begin n_fail++; $display("FAIL nosclk_pwm_hold: got %h expected 0321", pwm_ref); end
  endtask

  task automatic test_overrun;
    int v0;
    set_words(16'h8000, 16'h0777);
    v0 = valid_cnt;
    push_expected(12);
    xfer(13, 1'b1, 10);
    n_checks++; if (frame_error !== 1'b1) begin n_fail++; $display("FAIL overrun_frame_error: got %b expected 1", frame_error); end
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL overrun_pwm_valid: got %0d expected 0", valid_cnt - v0); end
  endtask

  task automatic test_snapshot;
    position = 32'sh0000_FFFF;
    set_words(16'h8000, 16'h0042);
    push_expected(12);
    fork
      xfer(12, 1'b1, 10);
      begin
        repeat (10 + 5 * 160 + 80) @(negedge clk);
        position = 32'sh0001_0000;
        velocity = 16'sh7FFF;
      end
    join
    n_checks++; if (pwm_ref !== 16'sh0042) begin n_fail++; $display("FAIL snap_pwm_ref: got %h expected 0042", pwm_ref); end
  endtask

  task automatic test_back_to_back;
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    set_words(16'h8000, 16'h0011);
    push_expected(12);
    xfer(12, 1'b1, 3);
    set_words(16'h8000, 16'h0022);
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_pwm_valid: got %0d expected 2", valid_cnt - v0); end
    n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d expected 2", done_cnt - d0); end
    n_checks++; if (pwm_ref !== 16'sh0022) begin n_fail++; $display("FAIL b2b_pwm_ref: got %h expected 0022", pwm_ref); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, d0;
    set_words(16'h8000, 16'h0999);
    v0 = valid_cnt; d0 = done_cnt;
    fork
      xfer(12, 1'b0, 10);
      begin
        repeat (10 + 3 * 160 + 60) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (pwm_ref !== 16'sh0000) begin n_fail++; $display("FAIL rstmid_pwm_ref: got %h expected 0000", pwm_ref); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_error: got %b expected 0", frame_error); end
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
      end
    join
    n_checks++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_pwm_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rstmid_frame_done: got %0d expected 0", done_cnt - d0); end
    n_checks++; if (pwm_ref !== 16'sh0000) begin n_fail++; $display("FAIL rstmid_pwm_after: got %h expected 0000", pwm_ref); end
    set_words(16'h8000, 16'h0050);
    push_expected(12);
    xfer(12, 1'b1, 10);
    n_checks++; if (pwm_ref !== 16'sh0050) begin n_fail++; $display("FAIL rstmid_next_pwm: got %h expected 0050", pwm_ref); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_error: got %b expected 0", frame_error); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_negative_pwm();
    test_bad_header();
    test_short_frame();
    test_no_sclk();
    test_overrun();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_frame();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
